// File: rtl/write_decode_pkg.sv
// write_decode_pkg: opcode constants, instruction field layout and the decoded-instruction record.
package write_decode_pkg;
    localparam logic [3:0] OP_LOAD      = 4'h1;
    localparam logic [3:0] OP_MAX_LEGAL = 4'h7;
    localparam logic [3:0] OP_NOP       = 4'hF;
    localparam int OP_LSB  = 24;
    localparam int RD_LSB  = 16;
    localparam int RS1_LSB = 11;
    localparam int RS2_LSB = 6;
    localparam int REG_W   = 5;
    localparam int IMM_W   = 16;

    typedef struct packed {
        logic [3:0]       op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [IMM_W-1:0] imm;
        logic             load;
        logic             we;
        logic             illegal;
    } dec_t;

    // Fields pass through raw; only the flag bits depend on legality.
    function automatic dec_t decode(input logic [31:0] i);
        dec_t d;
        d.op      = i[OP_LSB +: 4];
        d.rd      = i[RD_LSB +: REG_W];
        d.rs1     = i[RS1_LSB +: REG_W];
        d.rs2     = i[RS2_LSB +: REG_W];
        d.imm     = i[IMM_W-1:0];
        d.illegal = i[31:28] != 4'h0 || i[23:21] != 3'h0 || (d.op > OP_MAX_LEGAL && d.op != OP_NOP);
        d.load    = !d.illegal && d.op == OP_LOAD;
        d.we      = !d.illegal && d.op != OP_NOP;
        return d;
    endfunction
endpackage

// File: rtl/write_decode_mq_if.sv
// write_decode_mq_if: host write bus plus decoded-instruction output handshake.
interface write_decode_mq_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 5
);
    localparam int CH_W = $clog2(NUM_CH);
    logic [ADDR_W-1:0] write_addr;
    logic [31:0]       write_data;
    logic              write;
    logic [NUM_CH-1:0] wr_full;
    logic [7:0]        drop_count;
    logic              out_valid;
    logic              out_ready;
    logic [CH_W-1:0]   out_ch;
    logic [3:0]        operation;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [15:0]       imm;
    logic              load;
    logic              write_enable;
    logic              illegal;

    modport master (
        output write_addr, write_data, write, out_ready,
        input  wr_full, drop_count, out_valid, out_ch, operation, rd, rs1, rs2, imm, load, write_enable, illegal
    );
    modport slave (
        input  write_addr, write_data, write, out_ready,
        output wr_full, drop_count, out_valid, out_ch, operation, rd, rs1, rs2, imm, load, write_enable, illegal
    );
endinterface

// File: rtl/write_decode_mq_cmd_fifo.sv
// cmd_fifo: single-channel synchronous FIFO with synchronous flush; caller never pushes when full.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0] rp_q, rp_d, wp_q, wp_d;
    logic [AW:0] cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        wp_d  = push ? wp_q + 1'b1 : wp_q;
        rp_d  = pop ? rp_q + 1'b1 : rp_q;
        cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        if (push) mem_d[wp_q] = din;
        if (flush) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout  = mem_q[rp_q];
    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
endmodule

// File: rtl/write_decode_mq.sv
// write_decode_mq: per-channel instruction FIFOs drained round-robin into a registered decode stage.
module write_decode_mq
    import write_decode_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5
) (
    input logic              clk,
    input logic              rst,
    write_decode_mq_if.slave bus
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam logic [ADDR_W-1:0] FLUSH_ADDR = '1;

    logic [NUM_CH-1:0] push, pop, full, empty;
    logic [31:0] dout [NUM_CH];
    logic flush, drop, take, gnt_found;
    logic [CH_W-1:0] gnt_ch, ptr_q, ptr_d, ch_q, ch_d;
    logic valid_q, valid_d;
    logic [7:0] drop_q, drop_d;
    dec_t dec_q, dec_d;
    int idx;

    always_comb begin
        flush = bus.write && bus.write_addr == FLUSH_ADDR && bus.write_data[0];
        push  = '0;
        for (int c = 0; c < NUM_CH; c++)
            push[c] = bus.write && int'(bus.write_addr) == c && !full[c];
        drop      = bus.write && bus.write_addr != FLUSH_ADDR && push == '0;
        gnt_found = 1'b0;
        gnt_ch    = '0;
        idx       = 0;
        // Search starts just past the last grant so every channel gets a turn.
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = (int'(ptr_q) + i) % NUM_CH;
            if (!gnt_found && !empty[idx]) begin
                gnt_found = 1'b1;
                gnt_ch    = CH_W'(idx);
            end
        end
        take         = (!valid_q || bus.out_ready) && gnt_found && !flush;
        pop          = '0;
        pop[gnt_ch]  = take;
        valid_d      = flush ? 1'b0 : take ? 1'b1 : bus.out_ready ? 1'b0 : valid_q;
        ptr_d        = take ? gnt_ch : ptr_q;
        ch_d         = take ? gnt_ch : ch_q;
        dec_d        = take ? decode(dout[gnt_ch]) : dec_q;
        drop_d       = drop_q + 8'(drop && drop_q != 8'hFF);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= CH_W'(NUM_CH - 1);
            ch_q    <= '0;
            valid_q <= 1'b0;
            drop_q  <= '0;
            dec_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
            dec_q   <= dec_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        cmd_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (push[g]),
            .pop   (pop[g]),
            .din   (bus.write_data),
            .dout  (dout[g]),
            .full  (full[g]),
            .empty (empty[g])
        );
    end

    assign bus.wr_full      = full;
    assign bus.drop_count   = drop_q;
    assign bus.out_valid    = valid_q;
    assign bus.out_ch       = ch_q;
    assign bus.operation    = dec_q.op;
    assign bus.rd           = dec_q.rd;
    assign bus.rs1          = dec_q.rs1;
    assign bus.rs2          = dec_q.rs2;
    assign bus.imm          = dec_q.imm;
    assign bus.load         = dec_q.load;
    assign bus.write_enable = dec_q.we;
    assign bus.illegal      = dec_q.illegal;
endmodule

// File: tb/tb_write_decode_mq.sv
// tb_write_decode_mq: scoreboard bench; expected decodes are queued at drive time and popped on each handshake.
module tb_write_decode_mq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int tests = 0;
    int fails = 0;
    logic [39:0] q[$];

    write_decode_mq_if #(.NUM_CH(4), .ADDR_W(5)) bus();

    write_decode_mq dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] model(input logic [1:0] ch, input logic [31:0] w);
        logic [3:0] op = w[27:24];
        logic bad = w[31:28] != 0 || w[23:21] != 0 || (op >= 4'h8 && op <= 4'hE);
        logic ld = !bad && op == 4'h1;
        logic we = !bad && op != 4'hF;
        return {ch, op, w[20:16], w[15:11], w[10:6], w[15:0], ld, we, bad};
    endfunction

    // Called at posedge+1; returns at the next posedge+1 with write deasserted.
    task automatic wr(input logic [4:0] a, input logic [31:0] d, input bit exp);
        bus.write = 1'b1;
        bus.write_addr = a;
        bus.write_data = d;
        if (exp) q.push_back(model(a[1:0], d));
        @(posedge clk);
        #1 bus.write = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (q.size() != 0 && n < 40);
        #1 chk("drain_empty", q.size(), 0);
    endtask

    // Handshake seen at negedge completes at the next posedge unless a flush is being written.
    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready && !(bus.write && bus.write_addr == 5'd31 && bus.write_data[0])) begin
            logic [39:0] got;
            got = {bus.out_ch, bus.operation, bus.rd, bus.rs1, bus.rs2, bus.imm, bus.load, bus.write_enable, bus.illegal};
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_out: got %0h expected none", got);
            end else begin
                chk("out", got, q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.write = 1'b0;
        bus.write_addr = '0;
        bus.write_data = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_full", bus.wr_full, 0);
        chk("rst_drop", bus.drop_count, 0);
        chk("rst_dec", {bus.out_ch, bus.operation, bus.rd, bus.imm, bus.load, bus.write_enable, bus.illegal}, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        wr(5'd0, 32'h010DABCD, 1);
        chk("lat_not_yet", bus.out_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_valid", bus.out_valid, 1);
        chk("load_fields", {bus.out_ch, bus.operation, bus.load, bus.rd, bus.imm, bus.write_enable, bus.illegal},
            {2'd0, 4'h1, 1'b1, 5'd13, 16'hABCD, 1'b1, 1'b0});
        drain();
        wr(5'd3, 32'h00032140, 1);
        drain();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 6; k++) wr(5'd1, 32'h02000000 | (k << 16), k < 5);
        chk("ovf_full", bus.wr_full, 4'b0010);
        chk("ovf_drop1", bus.drop_count, 1);
        wr(5'd12, 32'h0, 0);
        chk("ovf_drop2", bus.drop_count, 2);
        bus.out_ready = 1'b1;
        drain();
        chk("ovf_full_clr", bus.wr_full, 0);
        bus.out_ready = 1'b0;
        wr(5'd0, 32'h020A0000, 0);
        wr(5'd0, 32'h020B0000, 0);
        wr(5'd2, 32'h030C0000, 0);
        wr(5'd2, 32'h030D0000, 0);
        chk("rr_hold", {bus.out_valid, bus.out_ch, bus.rd}, {1'b1, 2'd0, 5'h0A});
        q.push_back(model(2'd0, 32'h020A0000));
        q.push_back(model(2'd2, 32'h030C0000));
        q.push_back(model(2'd0, 32'h020B0000));
        q.push_back(model(2'd2, 32'h030D0000));
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rr_consec", q.size(), 0);
        chk("rr_idle", bus.out_valid, 0);
        wr(5'd0, 32'h09000000, 1);
        wr(5'd1, 32'h0F000000, 1);
        wr(5'd2, 32'h41000000, 1);
        wr(5'd3, 32'h07200000, 1);
        drain();
        for (int k = 0; k < 260; k++) wr(5'd20, 32'h0, 0);
        chk("drop_sat", bus.drop_count, 255);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) wr(5'd2, 32'h02000000 | (k << 16), 0);
        chk("fl_pre_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        wr(5'd31, 32'h1, 0);
        chk("fl_valid", bus.out_valid, 0);
        chk("fl_full", bus.wr_full, 0);
        repeat (3) @(posedge clk);
        #1 chk("fl_quiet", bus.out_valid, 0);
        bus.out_ready = 1'b0;
        wr(5'd0, 32'h02010000, 0);
        wr(5'd0, 32'h02020000, 0);
        wr(5'd9, 32'h0, 0);
        @(posedge clk);
        #1;
        chk("mid_valid", bus.out_valid, 1);
        chk("mid_drop", bus.drop_count, 255);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_drop", bus.drop_count, 0);
        chk("arst_full", bus.wr_full, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        bus.out_ready = 1'b1;
        wr(5'd0, 32'h02050000, 1);
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
